// File: rtl/tf_index_sequencer_pkg.sv
// rtl/tf_index_sequencer_pkg.sv - shared states, stage tables and stage-order constants
package tf_index_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [1:0] NTT_FIRST_P  = 2'd3;
    localparam logic [1:0] NTT_LAST_P   = 2'd0;
    localparam logic [1:0] INTT_FIRST_P = 2'd0;
    localparam logic [1:0] INTT_LAST_P  = 2'd3;

    // log2 of N(p): p=3 -> 2, p=2 -> 8, p=1/p=0 -> 32
    function automatic logic [2:0] n_log2(input logic [1:0] p);
        case (p)
            2'd3:    return 3'd1;
            2'd2:    return 3'd3;
            default: return 3'd5;
        endcase
    endfunction

    function automatic logic [5:0] n_count(input logic [1:0] p);
        return 6'd1 << n_log2(p);
    endfunction

    function automatic logic [4:0] first_k(input logic [1:0] p, input logic down);
        logic [5:0] top;
        top = n_count(p) - 6'd1;
        return down ? top[4:0] : 5'd0;
    endfunction

    // Twiddle table base offset of each stage inside the shared tf ROM
    function automatic logic [5:0] tf_base(input logic [1:0] p);
        case (p)
            2'd3:    return 6'd0;
            2'd2:    return 6'd2;
            2'd1:    return 6'd10;
            default: return 6'd42;
        endcase
    endfunction

endpackage

// File: rtl/tf_index_sequencer_stage_index_counter.sv
// rtl/tf_index_sequencer_stage_index_counter.sv - repeat counter plus up/down k counter with stage terminal count
module stage_index_counter #(
    parameter int BEATS_PER_STAGE = 64
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic [4:0] load_k_i,
    input  logic       step_i,
    input  logic       down_i,
    input  logic [2:0] n_log2_i,
    output logic [4:0] k_o,
    output logic       stage_last_o
);

    localparam int RW = $clog2(BEATS_PER_STAGE);

    logic [RW-1:0] rpt_q, rpt_d, rpt_max;
    logic [4:0]    k_q, k_d, k_last;
    logic [5:0]    n_m1;
    logic          row_last;

    assign rpt_max      = RW'((BEATS_PER_STAGE >> n_log2_i) - 1);
    assign n_m1         = (6'd1 << n_log2_i) - 6'd1;
    assign k_last       = down_i ? 5'd0 : n_m1[4:0];
    assign row_last     = (rpt_q == rpt_max);
    assign stage_last_o = row_last && (k_q == k_last);
    assign k_o          = k_q;

    // The owner reloads at the stage boundary, so k never steps past its terminal value
    always_comb begin
        rpt_d = rpt_q;
        k_d   = k_q;
        if (load_i) begin
            rpt_d = '0;
            k_d   = load_k_i;
        end else if (step_i) begin
            if (row_last) begin
                rpt_d = '0;
                k_d   = down_i ? k_q - 5'd1 : k_q + 5'd1;
            end else begin
                rpt_d = rpt_q + RW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rpt_q <= '0;
            k_q   <= '0;
        end else begin
            rpt_q <= rpt_d;
            k_q   <= k_d;
        end
    end

endmodule

// File: rtl/tf_index_sequencer.sv
// rtl/tf_index_sequencer.sv - NTT/INTT twiddle stage and index beat sequencer
module tf_index_sequencer
    import tf_index_sequencer_pkg::*;
#(
    parameter int BEATS_PER_STAGE = 64
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       mode_i,
    input  logic       ready_i,
    output logic       valid_o,
    output logic [1:0] p_o,
    output logic [4:0] k_o,
    output logic [3:0] conf_o,
    output logic       busy_o,
    output logic       done_o
);

    state_e     state_q, state_d;
    logic       mode_q, mode_d;
    logic [1:0] p_q, p_d, last_p;
    logic       valid_q, valid_d, busy_q, busy_d, done_q, done_d;
    logic [3:0] conf_q, conf_d;
    logic       cnt_load, cnt_step, stage_last;
    logic [4:0] cnt_load_k;

    assign last_p = mode_q ? INTT_LAST_P : NTT_LAST_P;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        p_d        = p_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        conf_d     = conf_q;
        cnt_load   = 1'b0;
        cnt_load_k = 5'd0;
        cnt_step   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d    = ST_RUN;
                    mode_d     = mode_i;
                    p_d        = mode_i ? INTT_FIRST_P : NTT_FIRST_P;
                    valid_d    = 1'b1;
                    busy_d     = 1'b1;
                    conf_d     = 4'b0001 << p_d;
                    cnt_load   = 1'b1;
                    cnt_load_k = first_k(p_d, mode_i);
                end
            end
            ST_RUN: begin
                if (ready_i) begin
                    if (stage_last && (p_q == last_p)) begin
                        state_d  = ST_DONE;
                        valid_d  = 1'b0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        p_d      = 2'd0;
                        conf_d   = 4'b0000;
                        cnt_load = 1'b1;
                    end else if (stage_last) begin
                        // Next stage is presented on the very next cycle: no bubble
                        p_d        = mode_q ? p_q + 2'd1 : p_q - 2'd1;
                        conf_d     = 4'b0001 << p_d;
                        cnt_load   = 1'b1;
                        cnt_load_k = first_k(p_d, mode_q);
                    end else begin
                        cnt_step = 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
            p_q     <= 2'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            conf_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            p_q     <= p_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            conf_q  <= conf_d;
        end
    end

    stage_index_counter #(
        .BEATS_PER_STAGE(BEATS_PER_STAGE)
    ) u_counter (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .load_i      (cnt_load),
        .load_k_i    (cnt_load_k),
        .step_i      (cnt_step),
        .down_i      (mode_q),
        .n_log2_i    (n_log2(p_q)),
        .k_o         (k_o),
        .stage_last_o(stage_last)
    );

    assign valid_o = valid_q;
    assign p_o     = p_q;
    assign conf_o  = conf_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_tf_index_sequencer.sv
// tb/tb_tf_index_sequencer.sv - self-checking bench for tf_index_sequencer
module tb_tf_index_sequencer;

    localparam int BEATS = 64;
    localparam int TOTAL = 4 * BEATS;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       start_i = 1'b0;
    logic       mode_i = 1'b0;
    logic       ready_i = 1'b0;
    logic       valid_o, busy_o, done_o;
    logic [1:0] p_o;
    logic [4:0] k_o;
    logic [3:0] conf_o;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_p[TOTAL];
    int exp_k[TOTAL];

    typedef struct {
        bit rst_n;
        bit start;
        bit mode;
        bit ready;
        int e_v, e_b, e_d, e_c, e_p, e_k;
    } vec_t;

    vec_t tbl[10];

    tf_index_sequencer #(.BEATS_PER_STAGE(BEATS)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .start_i(start_i),
        .mode_i (mode_i),
        .ready_i(ready_i),
        .valid_o(valid_o),
        .p_o    (p_o),
        .k_o    (k_o),
        .conf_o (conf_o),
        .busy_o (busy_o),
        .done_o (done_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int pack(input int v, input int b, input int d, input int c,
                                input int pp, input int kk);
        return (v << 15) | (b << 14) | (d << 13) | (c << 9) | (pp << 5) | kk;
    endfunction

    function automatic int act();
        return pack(valid_o, busy_o, done_o, conf_o, p_o, k_o);
    endfunction

    task automatic check(input string name, input int a, input int r);
        n_tests++;
        if (a !== r) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, a, r);
        end
    endtask

    // Expected beat list straight from the stage/index/repeat rules
    function automatic void build(input bit md);
        int idx = 0;
        for (int s = 0; s < 4; s++) begin
            int pp = md ? s : 3 - s;
            int n  = (pp == 3) ? 2 : (pp == 2) ? 8 : 32;
            int r  = BEATS / n;
            for (int j = 0; j < n; j++) begin
                int kk = md ? n - 1 - j : j;
                for (int t = 0; t < r; t++) begin
                    exp_p[idx] = pp;
                    exp_k[idx] = kk;
                    idx++;
                end
            end
        end
    endfunction

    // Caller must be at a negedge; returns at the negedge after the done pulse
    task automatic do_run(input bit md, input int pct, input bit rand_mode,
                          input bit hold_start, input int stall_idx, input int exp_done_cyc);
        int idx = 0;
        int cyc = 0;
        int stall = 0;
        bit fin = 0;
        build(md);
        start_i = 1'b1;
        mode_i  = md;
        ready_i = 1'b1;
        while (!fin && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (!hold_start) start_i = 1'b0;
            if (rand_mode) mode_i = 1'($urandom_range(1, 0));
            if (done_o) begin
                fin = 1;
                check("accepted_beats", idx, TOTAL);
                check("done_outputs", act(), pack(0, 0, 1, 0, 0, 0));
                if (exp_done_cyc > 0) check("done_latency", cyc, exp_done_cyc);
            end else begin
                int e = (idx < TOTAL) ? idx : TOTAL - 1;
                check("beat", act(), pack(1, 1, 0, 1 << exp_p[e], exp_p[e], exp_k[e]));
            end
            if (idx == stall_idx && stall < 3) begin
                ready_i = 1'b0;
                stall++;
            end else begin
                ready_i = ($urandom_range(99, 0) < pct);
            end
            if (valid_o && ready_i) idx++;
        end
        if (!fin) check("run_timeout", 0, 1);
        mode_i = md;
        @(negedge clk);
        check("post_done_idle", act(), 0);
    endtask

    initial begin
        tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2] = '{1, 1, 0, 0, 1, 1, 0, 8, 3, 0};
        tbl[3] = '{1, 0, 0, 0, 1, 1, 0, 8, 3, 0};
        tbl[4] = '{1, 0, 0, 1, 1, 1, 0, 8, 3, 0};
        tbl[5] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[6] = '{1, 1, 1, 1, 1, 1, 0, 1, 0, 31};
        tbl[7] = '{1, 0, 1, 1, 1, 1, 0, 1, 0, 31};
        tbl[8] = '{1, 0, 1, 1, 1, 1, 0, 1, 0, 30};
        tbl[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rst_ni  = tbl[i].rst_n;
            start_i = tbl[i].start;
            mode_i  = tbl[i].mode;
            ready_i = tbl[i].ready;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), act(),
                  pack(tbl[i].e_v, tbl[i].e_b, tbl[i].e_d, tbl[i].e_c, tbl[i].e_p, tbl[i].e_k));
        end

        @(negedge clk);
        rst_ni  = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        check("idle_after_reset", act(), 0);

        do_run(0, 100, 0, 0, -1, 257);
        do_run(1, 100, 0, 0, -1, 257);
        do_run(0, 50, 0, 0, -1, 0);
        do_run(1, 50, 0, 0, -1, 0);
        do_run(0, 100, 0, 0, 63, 260);

        // Reset in the middle of an NTT run
        start_i = 1'b1;
        mode_i  = 1'b0;
        ready_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (100) @(negedge clk);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_reset_outputs", act(), 0);
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk);
        check("no_beat_after_reset", act(), 0);
        do_run(0, 100, 0, 0, -1, 257);

        // start held high with mode toggling: one run per IDLE visit
        do_run(0, 100, 1, 1, -1, 257);
        do_run(0, 100, 1, 1, -1, 257);
        start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_after_held_start", act(), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
